// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - parallel-to-serial transmitter with generated sclk and frame strobe
//
// Purpose: accepts a WIDTH-bit word on a start/ready handshake and shifts it out
// bit-serially. The far end captures sdo_out on rising sclk_out edges.
//
// Optional build macro: PARITY_EN appends one even-parity bit (XOR of the data
// bits) after the data bits, in its own bit period.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-high
//   start     in   request to send data_in; accepted only when ready=1
//   data_in   in   word to send; sampled on the accepting edge only
//   ready     out  1 in IDLE: a start will be accepted
//   busy      out  1 while a frame is in progress (SHIFT or DONE)
//   done      out  one-cycle pulse after the last bit completes
//   sdo_out   out  serial data
//   sclk_out  out  serial clock; idles low
//   cs_n_out  out  frame strobe, low during SHIFT; idles high
module serial_tx_shifter #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sdo_out,
    output logic             sclk_out,
    output logic             cs_n_out
);

`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    // Divider counts 0 .. 2*CLK_DIV-1 across one bit period; sclk is high in
    // the upper half, so data (updated at count wrap) is stable at the rise.
    localparam int DIV_TC = 2 * CLK_DIV - 1;
    localparam int DIV_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W  = $clog2(NBITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [NBITS-1:0]   shreg;
    logic [NBITS-1:0]   load_word;
    logic               div_last;
    logic               bit_last;

    assign div_last = (div_cnt == DIV_W'(DIV_TC));
    assign bit_last = (bit_cnt == BIT_W'(NBITS - 1));

    // The parity bit is placed at the end of the shift order so it always
    // leaves after the data bits, whichever direction is selected.
    always_comb begin
        load_word = '0;
`ifdef PARITY_EN
        if (MSB_FIRST != 0) begin
            load_word = {data_in, ^data_in};
        end else begin
            load_word = {^data_in, data_in};
        end
`else
        load_word = data_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= load_word;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (MSB_FIRST != 0) begin
                            shreg <= {shreg[NBITS-2:0], 1'b0};
                        end else begin
                            shreg <= {1'b0, shreg[NBITS-1:1]};
                        end
                        if (bit_last) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sdo_out    = 1'b0;
        sclk_out   = 1'b0;
        cs_n_out   = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                cs_n_out = 1'b0;
                sclk_out = (div_cnt >= DIV_W'(CLK_DIV));
                sdo_out  = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];
                if (div_last && bit_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb/tb_serial_tx_shifter.sv - self-checking bench for serial_tx_shifter
module tb_serial_tx_shifter;

    localparam int W = 8;
    localparam int D = 2;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int FRAME = NB * 2 * D;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] data_a, data_b;
    logic       ready_a, busy_a, done_a, sdo_a, sclk_a, csn_a;
    logic       ready_b, busy_b, done_b, sdo_b, sclk_b, csn_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
        .ready(ready_a), .busy(busy_a), .done(done_a),
        .sdo_out(sdo_a), .sclk_out(sclk_a), .cs_n_out(csn_a)
    );

    serial_tx_shifter #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_b),
        .ready(ready_b), .busy(busy_b), .done(done_b),
        .sdo_out(sdo_b), .sclk_out(sclk_b), .cs_n_out(csn_b)
    );

    typedef struct {
        logic [7:0] data;
        bit         lsb;
        int         ign_at;
        logic [7:0] ign_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            start_b = s;
            data_b  = d;
        end else begin
            start_a = s;
            data_a  = d;
        end
    endtask

    task automatic get(input bit sel, output logic r, output logic b, output logic dn,
                       output logic sd, output logic sc, output logic cs);
        if (sel) begin
            r = ready_b; b = busy_b; dn = done_b; sd = sdo_b; sc = sclk_b; cs = csn_b;
        end else begin
            r = ready_a; b = busy_a; dn = done_a; sd = sdo_a; sc = sclk_a; cs = csn_a;
        end
    endtask

    // Expected transmit order, first bit in the most significant position.
    function automatic int model_word(input logic [7:0] d, input bit lsb);
        int w = 0;
        bit b;
        for (int i = 0; i < NB; i++) begin
            if (i < W) begin
                b = lsb ? d[i] : d[W-1-i];
            end else begin
                b = ^d;
            end
            w = (w << 1) | int'(b);
        end
        return w;
    endfunction

    task automatic idle_state(input bit sel, input string name);
        logic r, b, dn, sd, sc, cs;
        get(sel, r, b, dn, sd, sc, cs);
        check(name, int'({r, b, dn, sd, sc, cs}), int'(6'b100001));
    endtask

    task automatic run_frame(input bit sel, input logic [7:0] d, input int ign_at,
                             input logic [7:0] ign_d);
        logic r, b, dn, sd, sc, cs;
        logic prev_sc = 1'b0;
        int word = 0, nsamp = 0, done_k = 0, ndone = 0, busy_err = 0, cs_err = 0;
        string tag;
        tag = $sformatf("%s_%02h", sel ? "lsb" : "msb", d);
        get(sel, r, b, dn, sd, sc, cs);
        check({tag, " ready_before"}, int'(r), 1);
        drive(sel, 1'b1, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'($urandom));
        for (int k = 1; k <= FRAME + 6; k++) begin
            get(sel, r, b, dn, sd, sc, cs);
            if (sc && !prev_sc) begin
                word = (word << 1) | int'(sd);
                nsamp++;
            end
            prev_sc = sc;
            if (dn) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
            if (b !== logic'(k <= FRAME + 1)) busy_err++;
            if (cs !== logic'(k > FRAME)) cs_err++;
            if (k == ign_at) drive(sel, 1'b1, ign_d);
            else if (k == ign_at + 1) drive(sel, 1'b0, ign_d);
            @(posedge clk); #1;
        end
        check({tag, " sclk_pulses"}, nsamp, NB);
        check({tag, " bits"}, word, model_word(d, sel));
        check({tag, " done_latency"}, done_k, FRAME + 1);
        check({tag, " done_count"}, ndone, 1);
        check({tag, " busy_window"}, busy_err, 0);
        check({tag, " cs_window"}, cs_err, 0);
        idle_state(sel, {tag, " idle_after"});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic r, b, dn, sd, sc, cs;
        logic prev_sc;
        int   ndone, second, word, nsamp;

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        idle_state(0, "reset_msb");
        idle_state(1, "reset_lsb");
        rst = 1'b0;
        @(posedge clk); #1;
        idle_state(0, "released_msb");
        idle_state(1, "released_lsb");

        vecs[0] = '{8'hA5, 1'b0, 0,  8'h00};
        vecs[1] = '{8'h01, 1'b1, 0,  8'h00};
        vecs[2] = '{8'h3C, 1'b0, 10, 8'hFF};
        vecs[3] = '{8'hC3, 1'b1, 7,  8'h00};
        vecs[4] = '{8'h00, 1'b0, 0,  8'h00};
        vecs[5] = '{8'hFF, 1'b1, FRAME + 1, 8'h55};
        vecs[6] = '{8'h07, 1'b0, FRAME, 8'hAA};
        vecs[7] = '{8'h80, 1'b1, 0,  8'h00};
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].lsb, vecs[i].data, vecs[i].ign_at, vecs[i].ign_data);
        end

        for (int i = 0; i < 10; i++) begin
            run_frame(1'($urandom), 8'($urandom), 0, 8'h00);
        end

        // Reset at the start of the 4th bit; nothing may survive it.
        drive(0, 1'b1, 8'h3C);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00);
        repeat (3 * 2 * D) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_state(0, "midframe_reset");
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_a) ndone++;
            @(posedge clk); #1;
        end
        check("midframe_no_done", ndone, 0);
        idle_state(0, "midframe_stays_idle");
        run_frame(0, 8'h5A, 0, 8'h00);

        // Reset and start on the same edge: reset wins.
        rst = 1'b1;
        drive(0, 1'b1, 8'hAA);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        idle_state(0, "rst_beats_start");
        @(posedge clk); #1;
        idle_state(0, "rst_beats_start_later");

        // start held high: back-to-back frames with exactly one idle cycle.
        drive(0, 1'b1, 8'h96);
        @(posedge clk); #1;
        ndone = 0; second = 0; word = 0; nsamp = 0; prev_sc = 1'b0;
        for (int k = 1; k <= 2 * FRAME + 6; k++) begin
            get(0, r, b, dn, sd, sc, cs);
            if (dn) ndone++;
            if (!cs && k > FRAME && second == 0) second = k;
            if (k > FRAME + 2 && sc && !prev_sc) begin
                word = (word << 1) | int'(sd);
                nsamp++;
            end
            prev_sc = sc;
            if (k == FRAME + 4) drive(0, 1'b0, 8'h00);
            @(posedge clk); #1;
        end
        check("held_start_second_frame_cycle", second, FRAME + 3);
        check("held_start_done_count", ndone, 2);
        check("held_start_second_bits", word, model_word(8'h96, 1'b0));
        check("held_start_second_pulses", nsamp, NB);
        idle_state(0, "held_start_idle_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
